im_loader: RTL and testbench



---
 rtl/im_loader.sv | 172 +++++++++++++++++
 tb/tb_im_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words and
// writes them to consecutive word addresses. Optional checksum: IM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module im_loader #(
  parameter int MAX_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  wordCount,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  input  logic [31:0] cpuPc,
  output logic [31:0] pc,
  output logic [31:0] dataIn,
  output logic        memWrite,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [4:0] MAX_CNT = 5'(MAX_WORDS);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [1:0]  byte_cnt_q;
  logic [4:0]  count_q;
  logic [4:0]  count_d;
  logic [31:0] data_q;
  logic        mem_write_q;
  logic        byte_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        last_word;
  logic        byte_take;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    count_d = wordCount;
    if (wordCount > MAX_CNT) count_d = MAX_CNT;
  end

  assign last_word = (({1'b0, idx_q} + 5'd1) == count_q);
  assign byte_take = byteValid && byte_ready_q;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      count_q      <= '0;
      data_q       <= '0;
      mem_write_q  <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            count_q    <= count_d;
            if (count_d == 5'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_COLLECT;
              byte_ready_q <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (byte_take) begin
            // Big-endian: the first byte of a word lands in the top lane.
            unique case (byte_cnt_q)
              2'd0: data_q[31:24] <= byteIn;
              2'd1: data_q[23:16] <= byteIn;
              2'd2: data_q[15:8]  <= byteIn;
              2'd3: data_q[7:0]   <= byteIn;
            endcase
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              mem_write_q  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          idx_q <= idx_q + 4'd1;
          if (last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_q      <= S_CHECK;
            byte_ready_q <= 1'b1;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q      <= S_COLLECT;
            byte_ready_q <= 1'b1;
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_take) begin
            state_q      <= S_DONE;
            byte_ready_q <= 1'b0;
            done_q       <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       err_q;

  // Running XOR of data bytes; err is decided on the checksum byte and held until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == S_COLLECT && byte_take) begin
      csum_q <= csum_q ^ byteIn;
    end else if (state_q == S_CHECK && byte_take) begin
      err_q <= (byteIn != csum_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign byteReady = byte_ready_q;
  assign memWrite  = mem_write_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dataIn    = data_q;
  assign pc        = busy_q ? {26'b0, idx_q, 2'b00} : cpuPc;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: stimulus queues expected memory writes, a
// falling-edge monitor pops and compares them when memWrite is seen.
`timescale 1ns/1ps

module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  wordCount = '0;
  logic [7:0]  byteIn = '0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [31:0] cpuPc = 32'h0000_0024;
  logic [31:0] pc;
  logic [31:0] dataIn;
  logic        memWrite;
  logic        busy;
  logic        done;
  logic        err;

  im_loader #(.MAX_WORDS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .wordCount (wordCount),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .cpuPc     (cpuPc),
    .pc        (pc),
    .dataIn    (dataIn),
    .memWrite  (memWrite),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  n_writes = 0;
  int  cyc = 0;
  int  start_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  always @(posedge clk) cyc++;

  // Memory samples on the falling edge, so the monitor does too.
  always @(negedge clk) begin
    if (memWrite === 1'b1) begin
      wr_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_pc", pc, e.addr);
        check("write_data", dataIn, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    byteIn    = b;
    byteValid = 1'b1;
    while (byteReady !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("byte_ready_timeout", 32'(byteReady), 32'd1);
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_check(input logic [7:0] ck);
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(ck);
`else
    byteIn = ck;
`endif
  endtask

  task automatic do_start(input logic [4:0] n);
    start     = 1'b1;
    wordCount = n;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic exp_err);
    int guard = 0;
    byteValid = 1'b0;
    while (done !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check({name, "_latency"}, 32'(cyc - start_cyc + 1), 32'(exp_lat));
    check({name, "_err"}, 32'(err), 32'(exp_err));
    tick();
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [31:0] w;
    logic [7:0]  ck;

    repeat (3) tick();
    reset = 1'b0;
    check("rst_pc", pc, 32'h0000_0024);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memwrite", 32'(memWrite), 32'd0);
    check("rst_byteready", 32'(byteReady), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_datain", dataIn, 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Two words back-to-back
    w0 = n_writes;
    exp_q.push_back('{addr: 32'h0, data: 32'hD66A_0000});
    exp_q.push_back('{addr: 32'h4, data: 32'h811B_0000});
    do_start(5'd2);
    send_word(32'hD66A_0000);
    send_word(32'h811B_0000);
    send_check(8'h26);
    wait_done("two_words", 11 + CK, 1'b0);
    check("two_words_count", 32'(n_writes - w0), 32'd2);

    // Count 20 clamps to 16
    w0 = n_writes;
    ck = 8'h00;
    for (int i = 0; i < 16; i++) begin
      w = {8'(8'h10 + i), 8'(8'hA0 + i), 8'h0F, 8'(8'hC3 ^ i)};
      ck = ck ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_q.push_back('{addr: 32'(i * 4), data: w});
    end
    do_start(5'd20);
    for (int i = 0; i < 16; i++) begin
      w = {8'(8'h10 + i), 8'(8'hA0 + i), 8'h0F, 8'(8'hC3 ^ i)};
      send_word(w);
    end
    send_check(ck);
    wait_done("clamp16", 81 + CK, 1'b0);
    check("clamp16_count", 32'(n_writes - w0), 32'd16);

    // Count 0: immediate done, no writes
    w0 = n_writes;
    do_start(5'd0);
    wait_done("zero", 1, 1'b0);
    check("zero_count", 32'(n_writes - w0), 32'd0);

    // Stall between bytes 2 and 3, with a stray start pulse
    w0 = n_writes;
    exp_q.push_back('{addr: 32'h0, data: 32'h1122_3344});
    do_start(5'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    byteValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_data", {8'h00, dataIn[31:8]}, 32'h0011_2233);
      check("stall_nowrite", 32'(memWrite), 32'd0);
      check("stall_pc", pc, 32'h0);
      start     = (k == 0);
      wordCount = 5'd5;
      tick();
    end
    start = 1'b0;
    send_byte(8'h44);
    send_check(8'h44);
    wait_done("stall", 9 + CK, 1'b0);
    repeat (3) tick();
    check("stall_count", 32'(n_writes - w0), 32'd1);
    check("stall_start_ignored", 32'(busy), 32'd0);

    // Reset during the second COLLECT
    w0 = n_writes;
    cpuPc = 32'h0000_0100;
    exp_q.push_back('{addr: 32'h0, data: 32'hCAFE_F00D});
    do_start(5'd3);
    send_word(32'hCAFE_F00D);
    send_byte(8'hAB);
    send_byte(8'hCD);
    byteValid = 1'b0;
    check("collect2_pc", pc, 32'h4);
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_memwrite", 32'(memWrite), 32'd0);
    check("midrst_byteready", 32'(byteReady), 32'd0);
    check("midrst_pc", pc, 32'h0000_0100);
    reset = 1'b0;
    repeat (6) tick();
    check("midrst_count", 32'(n_writes - w0), 32'd1);

`ifdef IM_LOADER_CHECKSUM_EN
    exp_q.push_back('{addr: 32'h0, data: 32'h1234_5678});
    do_start(5'd1);
    send_word(32'h1234_5678);
    send_byte(8'h08);
    wait_done("ck_good", 7, 1'b0);
    exp_q.push_back('{addr: 32'h0, data: 32'h1234_5678});
    do_start(5'd1);
    send_word(32'h1234_5678);
    send_byte(8'h09);
    wait_done("ck_bad", 7, 1'b1);
    check("ck_err_hold", 32'(err), 32'd1);
    do_start(5'd0);
    check("ck_err_clear", 32'(err), 32'd0);
    wait_done("ck_clear", 1, 1'b0);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
